vga_scan_ctrl: RTL

- Sequences the display scan for the game: divides the system clock into a pixel tick and steps an x/y raster over the full horizontal/vertical timing.
- Derives hsync/vsync/active from the raster position.
- Arbitrates game-logic update access so object/state updates are granted only during vertical blank, at most once per frame.
- Sits between the top-level clock and the sprite/collision renderers and game-state logic.

---
 rtl/vga_scan_ctrl_if.sv | 31 +++
 rtl/vga_scan_ctrl.sv | 125 ++++++++++++
 2 files changed

// File: rtl/vga_scan_ctrl_if.sv
// Signal bundle between the scan controller and the game/render side.
// Names are from the controller's point of view: i_* go into it, o_* come out.
interface vga_scan_ctrl_if #(
    parameter int XBITS = 10,
    parameter int YBITS = 10
);
    logic             i_en;
    logic             i_upd_req;
    logic             i_upd_done;
    logic             o_pix_tick;
    logic [XBITS-1:0] o_x;
    logic [YBITS-1:0] o_y;
    logic             o_active;
    logic             o_hsync_n;
    logic             o_vsync_n;
    logic             o_frame_start;
    logic             o_upd_gnt;
    logic             o_upd_overrun;

    modport master (
        output i_en, i_upd_req, i_upd_done,
        input  o_pix_tick, o_x, o_y, o_active, o_hsync_n, o_vsync_n,
               o_frame_start, o_upd_gnt, o_upd_overrun
    );

    modport slave (
        input  i_en, i_upd_req, i_upd_done,
        output o_pix_tick, o_x, o_y, o_active, o_hsync_n, o_vsync_n,
               o_frame_start, o_upd_gnt, o_upd_overrun
    );
endinterface

// File: rtl/vga_scan_ctrl.sv
// Pixel-tick divider, x/y raster with registered sync/active decode, and a
// once-per-frame vblank update-window arbiter for the game logic.
module vga_scan_ctrl #(
    parameter int DIV    = 4,
    parameter int H_VIS  = 640,
    parameter int H_FP   = 16,
    parameter int H_SYNC = 96,
    parameter int H_BP   = 48,
    parameter int V_VIS  = 480,
    parameter int V_FP   = 10,
    parameter int V_SYNC = 2,
    parameter int V_BP   = 33,
    parameter int XBITS  = 10,
    parameter int YBITS  = 10
) (
    input  logic           i_clk,
    input  logic           i_rst_n,
    vga_scan_ctrl_if.slave bus
);
    localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;
    localparam int DBITS = (DIV > 1) ? $clog2(DIV) : 1;

    localparam logic [DBITS-1:0] D_LAST   = DBITS'(DIV - 1);
    localparam logic [XBITS-1:0] X_LAST   = XBITS'(H_TOT - 1);
    localparam logic [XBITS-1:0] X_VIS    = XBITS'(H_VIS);
    localparam logic [XBITS-1:0] X_HS_BEG = XBITS'(H_VIS + H_FP);
    localparam logic [XBITS-1:0] X_HS_END = XBITS'(H_VIS + H_FP + H_SYNC);
    localparam logic [YBITS-1:0] Y_LAST   = YBITS'(V_TOT - 1);
    localparam logic [YBITS-1:0] Y_VIS    = YBITS'(V_VIS);
    localparam logic [YBITS-1:0] Y_VS_BEG = YBITS'(V_VIS + V_FP);
    localparam logic [YBITS-1:0] Y_VS_END = YBITS'(V_VIS + V_FP + V_SYNC);

    typedef enum logic [1:0] {ST_IDLE, ST_GRANT, ST_SERVED} state_t;

    state_t           r_state, w_state_next;
    logic [DBITS-1:0] r_div;
    logic [XBITS-1:0] r_x, w_x_next;
    logic [YBITS-1:0] r_y, w_y_next;
    logic             r_active, r_hsync_n, r_vsync_n;
    logic             r_frame_start, r_overrun, w_overrun_next;
    logic             w_tick, w_line_end, w_frame_end, w_vblank;

    assign w_tick      = bus.i_en && (r_div == D_LAST);
    assign w_line_end  = (r_x == X_LAST);
    assign w_frame_end = w_tick && w_line_end && (r_y == Y_LAST);
    assign w_vblank    = (r_y >= Y_VIS);

    always_comb begin
        w_x_next = r_x + 1'b1;
        w_y_next = r_y;
        if (w_line_end) begin
            w_x_next = '0;
            w_y_next = (r_y == Y_LAST) ? '0 : r_y + 1'b1;
        end
    end

    // Decode from the next position so sync/active change on the same edge as x/y.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_div         <= '0;
            r_x           <= '0;
            r_y           <= '0;
            r_active      <= 1'b1;
            r_hsync_n     <= 1'b1;
            r_vsync_n     <= 1'b1;
            r_frame_start <= 1'b0;
        end else begin
            r_frame_start <= w_frame_end;
            if (bus.i_en) begin
                r_div <= (r_div == D_LAST) ? '0 : r_div + 1'b1;
            end
            if (w_tick) begin
                r_x       <= w_x_next;
                r_y       <= w_y_next;
                r_active  <= (w_x_next < X_VIS) && (w_y_next < Y_VIS);
                r_hsync_n <= !((w_x_next >= X_HS_BEG) && (w_x_next < X_HS_END));
                r_vsync_n <= !((w_y_next >= Y_VS_BEG) && (w_y_next < Y_VS_END));
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= ST_IDLE;
            r_overrun <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_overrun <= w_overrun_next;
        end
    end

    // SERVED blocks re-grant until vblank ends, giving one window per frame.
    always_comb begin
        w_state_next   = r_state;
        w_overrun_next = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.i_upd_req && w_vblank) w_state_next = ST_GRANT;
            end
            ST_GRANT: begin
                if (bus.i_upd_done) begin
                    w_state_next = ST_SERVED;
                end else if (w_frame_end) begin
                    w_state_next   = ST_SERVED;
                    w_overrun_next = 1'b1;
                end
            end
            ST_SERVED: begin
                if (!w_vblank) w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    assign bus.o_pix_tick    = w_tick;
    assign bus.o_x           = r_x;
    assign bus.o_y           = r_y;
    assign bus.o_active      = r_active;
    assign bus.o_hsync_n     = r_hsync_n;
    assign bus.o_vsync_n     = r_vsync_n;
    assign bus.o_frame_start = r_frame_start;
    assign bus.o_upd_gnt     = (r_state == ST_GRANT);
    assign bus.o_upd_overrun = r_overrun;
endmodule
